// File: rtl/float_copro_ctrl.sv
// Integer coprocessor controller: single-cycle add/sub/mul and a 32-step restoring divider.
// Define FLOAT_COPRO_DIV_EN to build the divider; without it opcode 3 is treated as undefined.
module float_copro_ctrl #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        user_valid,
  input  logic [10:0] user_opcode,
  input  logic [31:0] user_op0,
  input  logic [31:0] user_op1,
  output logic [31:0] user_result,
  output logic        user_complete,
  output logic        busy
);

  localparam logic [10:0] OP_ADD = 11'd0;
  localparam logic [10:0] OP_SUB = 11'd1;
  localparam logic [10:0] OP_MUL = 11'd2;

`ifdef FLOAT_COPRO_DIV_EN
  localparam int          CNT_W  = $clog2(DIV_ITER);
  localparam logic [10:0] OP_DIV = 11'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd1,
    S_DIV  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd1
  } state_t;
`endif

  state_t      r_state;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_prod;
  logic [31:0] w_singleResult;

  assign w_sum  = user_op0 + user_op1;
  assign w_diff = user_op0 - user_op1;
  assign w_prod = user_op0 * user_op1;

  // Anything that is not a single-cycle arithmetic op (including div when it is not built) yields 0.
  always_comb begin
    w_singleResult = 32'd0;
    case (user_opcode)
      OP_ADD:  w_singleResult = w_sum;
      OP_SUB:  w_singleResult = w_diff;
      OP_MUL:  w_singleResult = w_prod;
      default: w_singleResult = 32'd0;
    endcase
  end

`ifdef FLOAT_COPRO_DIV_EN
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_rem;
  logic [31:0]      r_quot;
  logic [31:0]      r_divisor;
  logic [32:0]      w_remShift;
  logic             w_ge;
  logic [31:0]      w_remNext;
  logic [31:0]      w_quotNext;

  // The shifted remainder can briefly need 33 bits; once the divisor is taken off it fits in 32 again.
  assign w_remShift = {r_rem, r_quot[31]};
  assign w_ge       = (w_remShift >= {1'b0, r_divisor});
  assign w_remNext  = w_remShift[31:0] - (w_ge ? r_divisor : 32'd0);
  assign w_quotNext = {r_quot[30:0], w_ge};
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      user_result   <= 32'd0;
      user_complete <= 1'b0;
      busy          <= 1'b0;
`ifdef FLOAT_COPRO_DIV_EN
      r_cnt         <= '0;
      r_rem         <= 32'd0;
      r_quot        <= 32'd0;
      r_divisor     <= 32'd0;
`endif
    end else begin
      user_complete <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (user_valid) begin
            busy <= 1'b1;
`ifdef FLOAT_COPRO_DIV_EN
            if (user_opcode == OP_DIV) begin
              r_state   <= S_DIV;
              r_rem     <= 32'd0;
              r_quot    <= user_op0;
              r_divisor <= user_op1;
              r_cnt     <= CNT_W'(DIV_ITER - 1);
            end else begin
              user_result   <= w_singleResult;
              user_complete <= 1'b1;
              r_state       <= S_DONE;
            end
`else
            user_result   <= w_singleResult;
            user_complete <= 1'b1;
            r_state       <= S_DONE;
`endif
          end
        end
`ifdef FLOAT_COPRO_DIV_EN
        S_DIV: begin
          r_rem  <= w_remNext;
          r_quot <= w_quotNext;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            user_result   <= w_quotNext;
            user_complete <= 1'b1;
            r_state       <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
